// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read/status bundle between datapath and register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = $clog2(DEPTH_DEF),
    parameter int NRD    = 2
);
    logic                     clr;
    logic                     wea;
    logic [ADDR_W-1:0]        waddra;
    logic [DATA_W-1:0]        wdataa;
    logic                     web;
    logic [ADDR_W-1:0]        waddrb;
    logic [DATA_W-1:0]        wdatab;
    logic [NRD*ADDR_W-1:0]    raddr;
    logic [NRD*DATA_W-1:0]    rdata;
    logic                     ready;
    logic                     wr_drop;

    modport master (
        output clr, wea, waddra, wdataa, web, waddrb, wdatab, raddr,
        input  rdata, ready, wr_drop
    );

    modport slave (
        input  clr, wea, waddra, wdataa, web, waddrb, wdatab, raddr,
        output rdata, ready, wr_drop
    );
endinterface

// File: rtl/regfile_init_fsm.sv
// rtl/regfile_init_fsm.sv - init/run sequencer: clears every entry, owns ready and wr_drop
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wr_req_i,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o,
    output logic              ready_o,
    output logic              wr_drop_o
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              ready_q, ready_d;
    logic              wr_drop_q, wr_drop_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= INIT;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            INIT: begin
                if (clr_i) begin
                    idx_d = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RUN: begin
                if (clr_i) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
        // ready mirrors the next state so it is high exactly while RUN is registered
        ready_d   = (state_d == RUN);
        wr_drop_d = wr_drop_q | (wr_req_i & ~ready_q);
    end

    always_comb begin
        init_we_o   = (state_q == INIT) && !clr_i;
        init_addr_o = idx_q;
        ready_o     = ready_q;
        wr_drop_o   = wr_drop_q;
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-write, NRD-read register file with optional zero entry and bypass
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int              DATA_W   = DATA_W_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter int              ADDR_W   = $clog2(DEPTH),
    parameter int              NRD      = 2,
    parameter bit              ZERO_R0  = 1'b1,
    parameter bit              BYPASS   = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic         clock,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);
    logic                 init_we;
    logic [ADDR_W-1:0]    init_addr;
    logic                 ready;
    logic                 wr_drop;
    logic                 wr_ok;
    logic                 wa_en;
    logic                 wb_en;
    logic [NRD*DATA_W-1:0] rdata_all;
    logic [DATA_W-1:0]    mem_q [DEPTH];

    regfile_init_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_fsm (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .clr_i       (bus.clr),
        .wr_req_i    (bus.wea | bus.web),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .ready_o     (ready),
        .wr_drop_o   (wr_drop)
    );

    // a clr cycle discards any user write, including its bypass
    assign wr_ok = ready & ~bus.clr;
    assign wa_en = wr_ok & bus.wea & ~(ZERO_R0 && (bus.waddra == '0));
    assign wb_en = wr_ok & bus.web & ~(ZERO_R0 && (bus.waddrb == '0));

    // port B is written last so it wins a same-address conflict
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem_q[init_addr] <= INIT_VAL;
        end else begin
            if (wa_en) mem_q[bus.waddra] <= bus.wdataa;
            if (wb_en) mem_q[bus.waddrb] <= bus.wdatab;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem_q[ra];
            if (BYPASS && wr_ok) begin
                if (bus.wea && (bus.waddra == ra)) rv = bus.wdataa;
                if (bus.web && (bus.waddrb == ra)) rv = bus.wdatab;
            end
            if (!ready || (ZERO_R0 && (ra == '0))) rv = '0;
        end

        assign rdata_all[k*DATA_W +: DATA_W] = rv;
    end

    assign bus.rdata   = rdata_all;
    assign bus.ready   = ready;
    assign bus.wr_drop = wr_drop;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for bypass and non-bypass register file instances
module tb_regfile_mp;
    logic        clock;
    logic        reset_n;
    logic        clr;
    logic        wea, web;
    logic [4:0]  waddra, waddrb;
    logic [31:0] wdataa, wdatab;
    logic [9:0]  raddr;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if_a ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if_b ();

    assign if_a.clr = clr;    assign if_b.clr = clr;
    assign if_a.wea = wea;    assign if_b.wea = wea;
    assign if_a.web = web;    assign if_b.web = web;
    assign if_a.waddra = waddra; assign if_b.waddra = waddra;
    assign if_a.waddrb = waddrb; assign if_b.waddrb = waddrb;
    assign if_a.wdataa = wdataa; assign if_b.wdataa = wdataa;
    assign if_a.wdatab = wdatab; assign if_b.wdatab = wdatab;
    assign if_a.raddr  = raddr;  assign if_b.raddr  = raddr;

    regfile_mp #(.BYPASS(1'b1)) u_dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a));
    regfile_mp #(.BYPASS(1'b0)) u_dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [32];
    bit          exp_ready = 1'b0;
    logic [31:0] exp_qa [$];
    logic [31:0] exp_qb [$];
    int          n_edges;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input bit byp, input logic [4:0] a);
        if (!exp_ready || a == 5'd0) return 32'h0;
        if (byp && !clr) begin
            if (web && waddrb == a) return wdatab;
            if (wea && waddra == a) return wdataa;
        end
        return model[a];
    endfunction

    task automatic step();
        if (exp_ready && !clr) begin
            if (wea && waddra != 5'd0) model[waddra] = wdataa;
            if (web && waddrb != 5'd0) model[waddrb] = wdatab;
        end
        @(negedge clock);
    endtask

    task automatic rd(input int port, input logic [4:0] addr, input string tag);
        raddr[port*5 +: 5] = addr;
        exp_qa.push_back(exp_read(1'b1, addr));
        exp_qb.push_back(exp_read(1'b0, addr));
        #1;
        check_eq({tag, "_a"}, if_a.rdata[port*32 +: 32], exp_qa.pop_front());
        check_eq({tag, "_b"}, if_b.rdata[port*32 +: 32], exp_qb.pop_front());
    endtask

    task automatic wait_ready(input int drop_edge, output int n);
        n = 0;
        while (!if_a.ready && n < 100) begin
            wea    = (n == drop_edge - 1);
            waddra = 5'd12;
            wdataa = 32'hDEAD_BEEF;
            step();
            n++;
        end
        wea = 1'b0;
        exp_ready = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic wr(input bit a_en, input logic [4:0] aa, input logic [31:0] da,
                      input bit b_en, input logic [4:0] ab, input logic [31:0] db);
        wea = a_en; waddra = aa; wdataa = da;
        web = b_en; waddrb = ab; wdatab = db;
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; raddr = '0;
        wr(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        check_eq("rst_ready", {31'b0, if_a.ready}, 32'd0);
        check_eq("rst_drop", {31'b0, if_a.wr_drop}, 32'd0);
        rd(0, 5'd5, "rst_rdata");

        reset_n = 1'b1;
        wait_ready(10, n_edges);
        check_eq("init_edges", n_edges, 32);
        check_eq("init_ready_b", {31'b0, if_b.ready}, 32'd1);
        check_eq("drop_in_init", {31'b0, if_a.wr_drop}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            rd(i % 2, 5'(i), "init_clear");
            step();
        end

        wr(1, 5'd5, 32'h1234_5678, 0, 0, 0);
        rd(0, 5'd5, "wa5_same");
        step(); wr(0, 0, 0, 0, 0, 0);
        rd(0, 5'd5, "wa5_next");

        wr(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
        rd(1, 5'd0, "r0_same");
        step(); wr(0, 0, 0, 0, 0, 0);
        rd(1, 5'd0, "r0_next");

        wr(1, 5'd7, 32'h0000_AAAA, 1, 5'd7, 32'h0000_BBBB);
        rd(0, 5'd7, "conf_same");
        step(); wr(0, 0, 0, 0, 0, 0);
        rd(0, 5'd7, "conf_next");

        wr(1, 5'd8, 32'h0000_0808, 1, 5'd3, 32'h0000_0055);
        rd(0, 5'd3, "b3_same");
        rd(1, 5'd8, "a8_same");
        step(); wr(0, 0, 0, 0, 0, 0);
        rd(0, 5'd3, "b3_next");
        rd(1, 5'd8, "a8_next");
        check_eq("drop_sticky", {31'b0, if_b.wr_drop}, 32'd1);

        wr(1, 5'd9, 32'h0000_0099, 0, 0, 0);
        step(); wr(0, 0, 0, 0, 0, 0);
        rd(0, 5'd9, "w9");
        clr = 1'b1;
        wr(1, 5'd10, 32'h0000_0077, 0, 0, 0);
        rd(1, 5'd9, "clr_cycle");
        step();
        clr = 1'b0; wr(0, 0, 0, 0, 0, 0);
        exp_ready = 1'b0;
        check_eq("clr_ready_low", {31'b0, if_a.ready}, 32'd0);
        wait_ready(0, n_edges);
        check_eq("clr_edges", n_edges, 32);
        rd(0, 5'd9, "clr_a9");
        rd(1, 5'd10, "clr_a10");

        @(negedge clock);
        reset_n = 1'b0; exp_ready = 1'b0;
        rd(0, 5'd9, "rst_run_rdata");
        check_eq("rst_run_ready", {31'b0, if_a.ready}, 32'd0);
        check_eq("rst_run_drop", {31'b0, if_b.wr_drop}, 32'd0);
        step();
        reset_n = 1'b1;
        repeat (16) step();
        check_eq("mid_init_ready", {31'b0, if_a.ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", {31'b0, if_a.ready}, 32'd0);
        step();
        reset_n = 1'b1;
        wait_ready(0, n_edges);
        check_eq("rerun_edges", n_edges, 32);
        check_eq("rerun_drop", {31'b0, if_a.wr_drop}, 32'd0);

        wr(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd4, 32'hCAFE_0004);
        rd(0, 5'd4, "final_same");
        step(); wr(0, 0, 0, 0, 0, 0);
        rd(0, 5'd4, "final_next");
        rd(1, 5'd0, "final_r0");
        check_eq("run_write_nodrop", {31'b0, if_a.wr_drop}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
